// File: rtl/time_pkg.sv
// Shared BCD time types, limits and helpers, used by the time setter and the time-of-day counter.
package time_pkg;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD_MAX_HH = 8'h23;
  localparam bcd8_t BCD_MAX_MS = 8'h59;

  // True when both nibbles are decimal digits and the value does not exceed max.
  function automatic logic bcd_valid(input bcd8_t val, input bcd8_t max);
    return (val[7:4] <= 4'h9) && (val[3:0] <= 4'h9) && (val <= max);
  endfunction

  // BCD +1 that wraps to 00 once max is reached.
  function automatic bcd8_t bcd_inc_wrap(input bcd8_t val, input bcd8_t max);
    bcd8_t res;
    if (val >= max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'h9) begin
      res = {4'(val[7:4] + 4'h1), 4'h0};
    end else begin
      res = {val[7:4], 4'(val[3:0] + 4'h1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a once-per-second tick and a 50 % blink phase.
// While hold is high the count is forced to 0 and no tick is produced.
module tick_prescaler #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick,
  output logic blink_ph
);

  localparam int unsigned CNT_W = $clog2(CLK_FREQ_HZ);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CLK_FREQ_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_FREQ_HZ / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q;
  logic             at_tc;

  assign at_tc    = (cnt_q == CNT_TC);
  assign tick     = at_tc && !hold;
  assign blink_ph = blink_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (hold || at_tc) begin
      cnt_d = '0;
    end
  end

  // Blink phase trails the count by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= (cnt_q < CNT_HALF);
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Free-running 24 h BCD time-of-day counter with load/freeze control from the time setter.
// Optional hourly chime pulse enabled by defining BCD_TIME_CHIME_EN.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter bcd8_t       RST_HH      = 8'h12
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  set_en,
  input  logic  set_load,
  input  bcd8_t set_hh,
  input  bcd8_t set_mm,
  input  bcd8_t set_ss,
  output bcd8_t cur_hh,
  output bcd8_t cur_mm,
  output bcd8_t cur_ss,
  output logic  sec_p,
  output logic  blink_ph,
  output logic  chime_p
);

  bcd8_t hh_q, hh_d;
  bcd8_t mm_q, mm_d;
  bcd8_t ss_q, ss_d;
  logic  sec_p_q, sec_p_d;
  logic  tick;
  logic  ss_wrap, mm_wrap;

  // A load also clears the prescaler so the next second is a full period.
  tick_prescaler #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .hold     (set_en || set_load),
    .tick     (tick),
    .blink_ph (blink_ph)
  );

  assign ss_wrap = (ss_q == BCD_MAX_MS);
  assign mm_wrap = (mm_q == BCD_MAX_MS);

  always_comb begin
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    sec_p_d = 1'b0;
    if (set_load) begin
      hh_d = bcd_valid(set_hh, BCD_MAX_HH) ? set_hh : 8'h00;
      mm_d = bcd_valid(set_mm, BCD_MAX_MS) ? set_mm : 8'h00;
      ss_d = bcd_valid(set_ss, BCD_MAX_MS) ? set_ss : 8'h00;
    end else if (!set_en && tick) begin
      sec_p_d = 1'b1;
      ss_d    = bcd_inc_wrap(ss_q, BCD_MAX_MS);
      if (ss_wrap) begin
        mm_d = bcd_inc_wrap(mm_q, BCD_MAX_MS);
        if (mm_wrap) begin
          hh_d = bcd_inc_wrap(hh_q, BCD_MAX_HH);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh_q    <= RST_HH;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      sec_p_q <= 1'b0;
    end else begin
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      sec_p_q <= sec_p_d;
    end
  end

  assign cur_hh = hh_q;
  assign cur_mm = mm_q;
  assign cur_ss = ss_q;
  assign sec_p  = sec_p_q;

`ifdef BCD_TIME_CHIME_EN
  logic chime_q, chime_d;

  // Top of the hour, including midnight; never on a load or while frozen.
  always_comb begin
    chime_d = !set_load && !set_en && tick && ss_wrap && mm_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= chime_d;
    end
  end

  assign chime_p = chime_q;
`else
  assign chime_p = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter at CLK_FREQ_HZ = 10: directed stimulus queues
// cycle-tagged expectations, a negedge monitor pops and compares them.
module tb_bcd_time_counter;

  localparam int unsigned CLK_HZ = 10;

`ifdef BCD_TIME_CHIME_EN
  localparam logic CHIME_EXP = 1'b1;
`else
  localparam logic CHIME_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       set_en, set_load;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       sec_p, blink_ph, chime_p;

  bcd_time_counter #(
    .CLK_FREQ_HZ (CLK_HZ),
    .RST_HH      (8'h12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_load (set_load),
    .set_hh   (set_hh),
    .set_mm   (set_mm),
    .set_ss   (set_ss),
    .cur_hh   (cur_hh),
    .cur_mm   (cur_mm),
    .cur_ss   (cur_ss),
    .sec_p    (sec_p),
    .blink_ph (blink_ph),
    .chime_p  (chime_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec;
    logic       blink;
    logic       chime;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the negedge that follows dk more rising edges.
  task automatic exp_at(input int dk, input logic [7:0] hh, input logic [7:0] mm,
                        input logic [7:0] ss, input logic sec, input logic blink,
                        input logic chime, input string nm);
    exp_t e;
    e.cyc   = cyc + dk;
    e.hh    = hh;
    e.mm    = mm;
    e.ss    = ss;
    e.sec   = sec;
    e.blink = blink;
    e.chime = chime;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
    end
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      checks++;
      if ({cur_hh, cur_mm, cur_ss, sec_p, blink_ph, chime_p} !==
          {e.hh, e.mm, e.ss, e.sec, e.blink, e.chime}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %h:%h:%h sec_p=%b blink=%b chime=%b, want %h:%h:%h sec_p=%b blink=%b chime=%b",
                 e.name, cyc, cur_hh, cur_mm, cur_ss, sec_p, blink_ph, chime_p,
                 e.hh, e.mm, e.ss, e.sec, e.blink, e.chime);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    set_en   = 1'b0;
    set_load = 1'b0;
    set_hh   = 8'h00;
    set_mm   = 8'h00;
    set_ss   = 8'h00;
    run(2);
    exp_at(0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "reset_state");
    run(1);
    rst = 1'b0;

    // 1: first second after reset, one-cycle sec_p on the 10th edge
    for (int k = 1; k <= 11; k++) begin
      exp_at(k, 8'h12, 8'h00, (k >= 10) ? 8'h01 : 8'h00, (k == 10), (((k - 1) % 10) < 5),
             1'b0, "t1_first_second");
    end
    run(11);

    // 2: load 23:59:58 then roll through midnight
    set_en = 1'b1; set_load = 1'b1;
    set_hh = 8'h23; set_mm = 8'h59; set_ss = 8'h58;
    exp_at(1, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 1'b0, "t2_load");
    run(1);
    set_en = 1'b0; set_load = 1'b0;
    exp_at(9,  8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 1'b0,      "t2_pre_tick");
    exp_at(10, 8'h23, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0,      "t2_to_59");
    exp_at(11, 8'h23, 8'h59, 8'h59, 1'b0, 1'b1, 1'b0,      "t2_pulse_end");
    exp_at(19, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0,      "t2_pre_midnight");
    exp_at(20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, CHIME_EXP, "t2_midnight");
    exp_at(21, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0,      "t2_after_midnight");
    run(21);

    // 3: set_en freezes time and prescaler for 50 clocks
    set_en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      exp_at(k, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "t3_frozen");
    end
    run(50);
    set_en = 1'b0;
    exp_at(9,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "t3_pre_tick");
    exp_at(10, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, "t3_first_tick");
    run(10);

    // 4: per-field sanitising of an out-of-range load
    set_load = 1'b1;
    set_hh = 8'h25; set_mm = 8'h3A; set_ss = 8'h45;
    exp_at(1, 8'h00, 8'h00, 8'h45, 1'b0, 1'b1, 1'b0, "t4_sanitise");
    run(1);
    set_load = 1'b0;

    // 5: load coinciding with the prescaler terminal count
    exp_at(8, 8'h00, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0, "t5_before_load");
    run(9);
    set_load = 1'b1;
    set_hh = 8'h10; set_mm = 8'h20; set_ss = 8'h30;
    exp_at(1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, "t5_load_at_tc");
    run(1);
    set_load = 1'b0;
    exp_at(9,  8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, "t5_pre_tick");
    exp_at(10, 8'h10, 8'h20, 8'h31, 1'b1, 1'b0, 1'b0, "t5_first_tick");
    run(10);

    // 6: async reset mid-second
    set_en = 1'b1; set_load = 1'b1;
    set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07;
    exp_at(1, 8'h05, 8'h06, 8'h07, 1'b0, 1'b1, 1'b0, "t6_load");
    run(1);
    set_en = 1'b0; set_load = 1'b0;
    exp_at(3, 8'h05, 8'h06, 8'h07, 1'b0, 1'b1, 1'b0, "t6_mid_second");
    run(4);
    rst = 1'b1;
    exp_at(0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "t6_async_reset");
    run(1);
    rst = 1'b0;
    exp_at(9,  8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "t6_pre_tick");
    exp_at(10, 8'h12, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, "t6_first_tick");
    run(10);

    run(2);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
